// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: slot record, allocator state
// encoding and the per-slot burst word layout consumed by pwm_combine.
package synth_pkg;

  localparam int VOICES     = 5;
  localparam int SLOT_AGE_W = 8;
  localparam int IDX_W      = 3;

  typedef struct packed {
    logic                  active;
    logic [6:0]            note;
    logic [6:0]            vel;
    logic [SLOT_AGE_W-1:0] age;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SETTLE = 2'd2
  } alloc_state_e;

  function automatic logic [15:0] pack_burst(input logic [6:0] note, input logic [6:0] vel);
    return {1'b0, note, 1'b0, vel};
  endfunction

endpackage

// File: rtl/oldest_slot_finder.sv
// Combinational search for the masked slot with the largest age; ties
// resolve to the lowest index. found_o is low when the mask is empty.
module oldest_slot_finder #(
  parameter int VOICES = 5,
  parameter int AGE_W  = 8,
  parameter int IDX_W  = 3
) (
  input  logic [VOICES*AGE_W-1:0] age_i,
  input  logic [VOICES-1:0]       mask_i,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    found_o
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    best_age = '0;
    // Strict greater-than keeps the earliest index on equal ages.
    for (int i = 0; i < VOICES; i++) begin
      if (mask_i[i] && (!found_o || (age_i[i*AGE_W +: AGE_W] > best_age))) begin
        idx_o    = IDX_W'(i);
        found_o  = 1'b1;
        best_age = age_i[i*AGE_W +: AGE_W];
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Maps note-on/off events onto mixer voice slots, stealing the oldest voice
// when full, and publishes coalesced slot snapshots after a quiet period.
module voice_allocator #(
  parameter int                VOICES        = 5,
  parameter logic [VOICES-1:0] USABLE_MASK   = 5'b11110,
  parameter int                SETTLE_CYCLES = 64,
  parameter int                AGE_W         = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   event_valid_in,
  output logic                   event_ready_out,
  input  logic                   event_on_in,
  input  logic [6:0]             event_note_in,
  input  logic [6:0]             event_vel_in,
  output logic [VOICES-1:0]      on_array_out,
  output logic [16*VOICES-1:0]   burst_data_out,
  output logic                   burst_change_out,
  output logic [2:0]             active_count_out,
  output logic                   steal_out
);
  import synth_pkg::*;

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SLOT_AGE_W-1:0] AGE_MAX = SLOT_AGE_W'((1 << AGE_W) - 1);

  alloc_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic                    ev_on_q, ev_on_d;
  logic [6:0]              ev_note_q, ev_note_d;
  logic [6:0]              ev_vel_q, ev_vel_d;
  slot_t                   slots_q [VOICES];
  slot_t                   slots_d [VOICES];
  logic [VOICES-1:0]       on_q, on_d;
  logic [16*VOICES-1:0]    data_q, data_d;
  logic [2:0]              count_q, count_d;
  logic                    burst_q, burst_d;
  logic                    steal_q, steal_d;

  logic                    accept;
  logic [VOICES-1:0]       live_mask, match_vec, free_vec;
  logic [VOICES*AGE_W-1:0] age_flat;
  logic [IDX_W-1:0]        old_idx, target;
  logic                    old_found, applied;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [VOICES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [SLOT_AGE_W-1:0] age_inc(input logic [SLOT_AGE_W-1:0] a);
    if (a >= AGE_MAX) return a;
    return a + SLOT_AGE_W'(1);
  endfunction

  function automatic logic [2:0] popcount(input logic [VOICES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < VOICES; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  assign event_ready_out  = (state_q == ST_IDLE) || (state_q == ST_SETTLE);
  assign accept           = event_valid_in && event_ready_out;
  assign on_array_out     = on_q;
  assign burst_data_out   = data_q;
  assign burst_change_out = burst_q;
  assign active_count_out = count_q;
  assign steal_out        = steal_q;

  always_comb begin
    live_mask = '0;
    match_vec = '0;
    free_vec  = '0;
    age_flat  = '0;
    for (int i = 0; i < VOICES; i++) begin
      live_mask[i] = USABLE_MASK[i] & slots_q[i].active;
      match_vec[i] = live_mask[i] && (slots_q[i].note == ev_note_q);
      free_vec[i]  = USABLE_MASK[i] & ~slots_q[i].active;
      age_flat[i*AGE_W +: AGE_W] = slots_q[i].age[AGE_W-1:0];
    end
  end

  oldest_slot_finder #(
    .VOICES (VOICES),
    .AGE_W  (AGE_W),
    .IDX_W  (IDX_W)
  ) u_oldest (
    .age_i   (age_flat),
    .mask_i  (live_mask),
    .idx_o   (old_idx),
    .found_o (old_found)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    ev_vel_d  = ev_vel_q;
    slots_d   = slots_q;
    on_d      = on_q;
    data_d    = data_q;
    count_d   = count_q;
    burst_d   = 1'b0;
    steal_d   = 1'b0;
    target    = '0;
    applied   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Velocity-zero note-on is a note-off in MIDI running-status practice.
          ev_on_d   = event_on_in && (event_vel_in != 7'd0);
          ev_note_d = event_note_in;
          ev_vel_d  = event_vel_in;
          state_d   = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (ev_on_q) begin
          if (|match_vec) begin
            target  = lowest_set(match_vec);
            applied = 1'b1;
          end else if (|free_vec) begin
            target  = lowest_set(free_vec);
            applied = 1'b1;
          end else if (old_found) begin
            target  = old_idx;
            applied = 1'b1;
            steal_d = 1'b1;
          end
          if (applied) begin
            for (int i = 0; i < VOICES; i++) begin
              if (IDX_W'(i) == target) begin
                slots_d[i].active = 1'b1;
                slots_d[i].note   = ev_note_q;
                slots_d[i].vel    = ev_vel_q;
                slots_d[i].age    = '0;
              end else if (slots_q[i].active) begin
                slots_d[i].age = age_inc(slots_q[i].age);
              end
            end
          end
        end else if (|match_vec) begin
          target  = lowest_set(match_vec);
          applied = 1'b1;
          for (int i = 0; i < VOICES; i++) begin
            if (IDX_W'(i) == target) slots_d[i] = '0;
          end
        end
        pending_d = pending_q | applied;
        cnt_d     = '0;
        state_d   = (applied || pending_q) ? ST_SETTLE : ST_IDLE;
      end

      ST_SETTLE: begin
        if (accept) begin
          ev_on_d   = event_on_in && (event_vel_in != 7'd0);
          ev_note_d = event_note_in;
          ev_vel_d  = event_vel_in;
          cnt_d     = '0;
          state_d   = ST_LOOKUP;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          // Quiet period elapsed: publish the shadowed slot state.
          for (int i = 0; i < VOICES; i++) begin
            on_d[i]             = USABLE_MASK[i] & slots_q[i].active;
            data_d[16*i +: 16]  = on_d[i] ? pack_burst(slots_q[i].note, slots_q[i].vel) : 16'h0000;
          end
          count_d   = popcount(on_d);
          burst_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_vel_q  <= '0;
      for (int i = 0; i < VOICES; i++) slots_q[i] <= '0;
      on_q      <= '0;
      data_q    <= '0;
      count_q   <= '0;
      burst_q   <= 1'b0;
      steal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      ev_vel_q  <= ev_vel_d;
      slots_q   <= slots_d;
      on_q      <= on_d;
      data_q    <= data_d;
      count_q   <= count_d;
      burst_q   <= burst_d;
      steal_q   <= steal_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a slot-level reference model predicts
// each burst snapshot and steal pulse; a negedge monitor checks what appears.
module tb_voice_allocator;

  localparam int V = 5;
  localparam int SETTLE = 64;
  localparam logic [V-1:0] USABLE = 5'b11110;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            event_valid_in = 1'b0;
  logic            event_ready_out;
  logic            event_on_in = 1'b0;
  logic [6:0]      event_note_in = '0;
  logic [6:0]      event_vel_in = '0;
  logic [V-1:0]    on_array_out;
  logic [16*V-1:0] burst_data_out;
  logic            burst_change_out;
  logic [2:0]      active_count_out;
  logic            steal_out;

  voice_allocator dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .event_valid_in   (event_valid_in),
    .event_ready_out  (event_ready_out),
    .event_on_in      (event_on_in),
    .event_note_in    (event_note_in),
    .event_vel_in     (event_vel_in),
    .on_array_out     (on_array_out),
    .burst_data_out   (burst_data_out),
    .burst_change_out (burst_change_out),
    .active_count_out (active_count_out),
    .steal_out        (steal_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [V-1:0]    on;
    logic [16*V-1:0] data;
    logic [2:0]      cnt;
  } exp_t;

  exp_t bq[$];
  int   sq[$];

  int m_act[V], m_note[V], m_vel[V], m_age[V];
  int m_deadline = -1;
  int last_k = 0;

  logic [V-1:0]    c_on   = '0;
  logic [16*V-1:0] c_data = '0;
  logic [2:0]      c_cnt  = '0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t snap(input int c);
    exp_t e;
    e.cyc = c; e.on = '0; e.data = '0; e.cnt = '0;
    for (int i = 0; i < V; i++) begin
      if (m_act[i] != 0) begin
        e.on[i] = 1'b1;
        e.data[16*i +: 16] = 16'(m_note[i] * 256 + m_vel[i]);
        e.cnt = e.cnt + 3'd1;
      end
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < V; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
    m_deadline = -1;
  endtask

  // Reference behaviour of one accepted event at cycle k.
  task automatic model_event(input bit on, input int note, input int vel, input int k);
    int  hit, tgt, best;
    bit  changed, is_on, pending;
    hit = -1; tgt = -1; best = -1; changed = 0;
    is_on   = on && (vel != 0);
    pending = (m_deadline >= k);
    for (int i = 0; i < V; i++)
      if (USABLE[i] && m_act[i] != 0 && m_note[i] == note && hit < 0) hit = i;
    if (is_on) begin
      if (hit >= 0) tgt = hit;
      else begin
        for (int i = 0; i < V; i++)
          if (USABLE[i] && m_act[i] == 0 && tgt < 0) tgt = i;
        if (tgt < 0) begin
          for (int i = 0; i < V; i++)
            if (USABLE[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
          tgt = best;
          if (tgt >= 0) sq.push_back(k + 1);
        end
      end
      if (tgt >= 0) begin
        changed = 1;
        for (int i = 0; i < V; i++) begin
          if (i == tgt) begin
            m_act[i] = 1; m_note[i] = note; m_vel[i] = vel; m_age[i] = 0;
          end else if (m_act[i] != 0) begin
            m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
          end
        end
      end
    end else if (hit >= 0) begin
      m_act[hit] = 0; m_note[hit] = 0; m_vel[hit] = 0; m_age[hit] = 0;
      changed = 1;
    end
    if (changed || pending) begin
      if (bq.size() > 0 && bq[bq.size()-1].cyc >= k) void'(bq.pop_back());
      bq.push_back(snap(k + 1 + SETTLE));
      m_deadline = k + 1 + SETTLE;
    end
  endtask

  task automatic send(input bit on, input int note, input int vel);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!event_ready_out) begin
      if (waited > 8) begin
        vectors++; miscompares++;
        $display("FAIL ready_timeout: ready stayed 0, expected 1 (cycle %0d)", cyc);
        return;
      end
      waited++;
      @(negedge clk);
    end
    event_valid_in = 1'b1;
    event_on_in    = on;
    event_note_in  = 7'(note);
    event_vel_in   = 7'(vel);
    @(posedge clk);
    #1;
    last_k = cyc;
    event_valid_in = 1'b0;
    model_event(on, note, vel, last_k);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_on_array", on_array_out, '0);
    check("rst_burst_data", burst_data_out, '0);
    check("rst_active_count", active_count_out, '0);
    check("rst_burst_change", burst_change_out, '0);
    check("rst_steal", steal_out, '0);
    model_clear();
    bq.delete();
    sq.delete();
    c_on = '0; c_data = '0; c_cnt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops expectations when the DUT pulses and tracks published state.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bq.size() > 0 && bq[0].cyc < cyc) begin
        e = bq.pop_front();
        vectors++; miscompares++;
        $display("FAIL missed_burst: no pulse seen, expected one at cycle %0d", e.cyc);
        c_on = e.on; c_data = e.data; c_cnt = e.cnt;
      end
      if (burst_change_out) begin
        if (bq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_burst: pulse at cycle %0d, expected none", cyc);
        end else begin
          e = bq.pop_front();
          check("burst_cycle", cyc, e.cyc);
          c_on = e.on; c_data = e.data; c_cnt = e.cnt;
        end
      end
      if (sq.size() > 0 && sq[0] < cyc) begin
        vectors++; miscompares++;
        $display("FAIL missed_steal: no steal pulse, expected one at cycle %0d", sq.pop_front());
      end
      if (steal_out) begin
        if (sq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_steal: pulse at cycle %0d, expected none", cyc);
        end else begin
          check("steal_cycle", cyc, sq.pop_front());
        end
      end
      check("on_array", on_array_out, c_on);
      check("burst_data", burst_data_out, c_data);
      check("active_count", active_count_out, c_cnt);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, g, note, vel;
    bit on;
    model_clear();
    do_reset();

    // Single note-on, then quiet.
    send(1, 60, 100);
    wait_to(last_k + 1 + SETTLE + 1);
    check("t1_on_array", on_array_out, 5'b00010);
    check("t1_slot1_word", burst_data_out[31:16], 16'h3C64);

    // Chord spaced 10 cycles: one pulse after the last note.
    do_reset();
    send(1, 60, 100);
    wait_to(last_k + 8); send(1, 64, 100);
    wait_to(last_k + 8); send(1, 67, 100);
    wait_to(last_k + 1 + SETTLE + 1);
    check("t2_on_array", on_array_out, 5'b01110);
    check("t2_active_count", active_count_out, 3'd3);

    // Fill all usable slots then steal the oldest.
    do_reset();
    for (int n = 60; n < 64; n++) send(1, n, 100);
    send(1, 64, 50);
    wait_to(last_k + 1);
    check("t3_steal_pulse", steal_out, 1'b1);
    wait_to(last_k + 1 + SETTLE + 1);
    check("t3_slot1_word", burst_data_out[31:16], 16'h4032);

    // Note-off of a held note; note-off of an unheld note from IDLE.
    do_reset();
    send(1, 60, 90); send(1, 61, 90); send(1, 62, 90);
    wait_to(last_k + 1 + SETTLE + 1);
    send(0, 61, 0);
    wait_to(last_k + 1 + SETTLE + 1);
    check("t4_on_array", on_array_out, 5'b01010);
    check("t4_slot2_word", burst_data_out[47:32], 16'h0000);
    send(0, 70, 0);
    wait_to(last_k + 80);

    // Velocity-zero note-on releases; duplicate note-on retunes in place.
    do_reset();
    send(1, 60, 100);
    wait_to(last_k + 1 + SETTLE + 1);
    send(1, 60, 0);
    wait_to(last_k + 1 + SETTLE + 1);
    check("t5_vel0_release", on_array_out, 5'b00000);
    send(1, 60, 50);
    wait_to(last_k + 1 + SETTLE + 1);
    send(1, 60, 20);
    wait_to(last_k + 1 + SETTLE + 1);
    check("t5_dup_on_array", on_array_out, 5'b00010);
    check("t5_dup_word", burst_data_out[31:16], 16'h3C14);

    // Event on the expiry cycle, then reset mid-settle.
    do_reset();
    send(1, 60, 100);
    k0 = last_k;
    wait_to(last_k + SETTLE - 1);
    send(1, 62, 100);
    check("t6_expiry_accept_cycle", last_k, k0 + 1 + SETTLE);
    wait_to(last_k + 1 + SETTLE + 1);
    check("t6_on_array", on_array_out, 5'b00110);
    send(1, 65, 100);
    wait_to(last_k + 30);
    do_reset();
    wait_to(cyc + 100);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      g    = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 70) : $urandom_range(0, 4);
      on   = ($urandom_range(0, 9) < 7);
      note = $urandom_range(58, 66);
      vel  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
      if ($urandom_range(0, 49) == 0) do_reset();
      wait_to(last_k + g);
      send(on, note, vel);
    end
    wait_to(last_k + 1 + SETTLE + 4);

    check("drain_burst_queue", bq.size(), 0);
    check("drain_steal_queue", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
